// File: rtl/count_pwm_gen_if.sv
// count_pwm_gen_if: valid/ready duty-write channel into the PWM generator's shadow register
interface count_pwm_gen_if #(parameter int WIDTH = 5);
   logic [WIDTH-1:0] duty_in;
   logic             duty_valid;
   logic             duty_ready;
   modport master (output duty_in, output duty_valid, input duty_ready);
   modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: glitch-free PWM from a counter timebase, duty shadowed until the next period boundary
module count_pwm_gen #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count_in,
   input  logic             enable,
   count_pwm_gen_if.slave   duty,
   output logic [WIDTH-1:0] duty_active,
   output logic             pwm_out,
   output logic             period_start
);
   localparam logic [1:0] DISABLED = 2'd0;
   localparam logic [1:0] SYNC     = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;
   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] prev_q, shadow, duty_eff;
   logic             shadow_full, bnd, apply, run_nx, pwm_nx;
   assign duty.duty_ready = ~shadow_full;
   // boundary detect, duty selection and next-state/next-output decode
   always_comb begin
      bnd      = count_in < prev_q;
      apply    = bnd && shadow_full;
      duty_eff = apply ? shadow : duty_active;
      run_nx   = enable && (state == RUN || (state == SYNC && bnd));
      state_nx = !enable ? DISABLED : (run_nx ? RUN : SYNC);
      pwm_nx   = run_nx && (count_in < duty_eff);
   end
   // timebase history, enable FSM and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q       <= '0;
         state        <= DISABLED;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         prev_q       <= count_in;
         state        <= state_nx;
         pwm_out      <= pwm_nx;
         period_start <= bnd;
      end
   end
   // shadow register: accept when empty, hand over to duty_active only at a boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow      <= '0;
         shadow_full <= 1'b0;
         duty_active <= '0;
      end else if (apply) begin
         duty_active <= shadow;
         shadow_full <= 1'b0;
      end else if (duty.duty_valid && !shadow_full) begin
         shadow      <= duty.duty_in;
         shadow_full <= 1'b1;
      end
   end
endmodule

// File: tb/tb_count_pwm_gen.sv
// tb_count_pwm_gen: directed-vector bench for the PWM generator driven by a modelled counter
module tb_count_pwm_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  count_in = '0;
   logic        enable = 1'b0;
   logic [4:0]  duty_active;
   logic        pwm_out, period_start;
   int          total = 0, passed = 0;
   int          hi_cnt, ps_cnt;
   logic [31:0] hi_mask;
   count_pwm_gen_if #(.WIDTH(5)) duty_if ();
   count_pwm_gen #(.WIDTH(5)) dut (
      .clk(clk), .rst(rst), .count_in(count_in), .enable(enable), .duty(duty_if),
      .duty_active(duty_active), .pwm_out(pwm_out), .period_start(period_start)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else passed++;
   endtask
   task automatic clr();
      hi_cnt = 0; ps_cnt = 0; hi_mask = '0;
   endtask
   task automatic step(input logic [4:0] nxt);
      @(posedge clk);
      #1;
      if (pwm_out) begin
         hi_cnt++;
         hi_mask[count_in] = 1'b1;
      end
      if (period_start) ps_cnt++;
      count_in = nxt;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(count_in + 5'd1);
   endtask
   initial begin
      duty_if.duty_in = '0;
      duty_if.duty_valid = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_ps", period_start, 0);
      chk("rst_active", duty_active, 0);
      chk("rst_ready", duty_if.duty_ready, 1);
      rst = 1'b1;
      enable = 1'b1;
      run(70);
      chk("free_ps_cnt", ps_cnt, 2);
      chk("free_hi", hi_cnt, 0);
      chk("free_active", duty_active, 0);
      duty_if.duty_valid = 1'b1;
      duty_if.duty_in = 5'd10;
      step(7);
      chk("d10_ready_drop", duty_if.duty_ready, 0);
      duty_if.duty_in = 5'd25;
      step(8);
      step(9);
      duty_if.duty_valid = 1'b0;
      clr();
      run(23);
      chk("d10_wait_active", duty_active, 0);
      chk("d10_wait_ready", duty_if.duty_ready, 0);
      chk("d10_wait_hi", hi_cnt, 0);
      clr();
      step(1);
      chk("d10_wrap_ps", period_start, 1);
      chk("d10_wrap_active", duty_active, 10);
      chk("d10_wrap_pwm", pwm_out, 1);
      chk("d10_wrap_ready", duty_if.duty_ready, 1);
      run(31);
      chk("d10_hi_cnt", hi_cnt, 10);
      chk("d10_hi_mask", hi_mask, 32'h0000_03ff);
      enable = 1'b0;
      duty_if.duty_valid = 1'b1;
      duty_if.duty_in = 5'd8;
      step(1);
      duty_if.duty_valid = 1'b0;
      chk("d8_off_pwm", pwm_out, 0);
      chk("d8_off_ps", period_start, 1);
      chk("d8_bnd_active", duty_active, 10);
      chk("d8_bnd_ready", duty_if.duty_ready, 0);
      clr();
      run(31);
      chk("d8_off_hi", hi_cnt, 0);
      step(1);
      chk("d8_active", duty_active, 8);
      run(16);
      chk("en17_count", count_in, 17);
      enable = 1'b1;
      clr();
      run(15);
      chk("en17_sync_hi", hi_cnt, 0);
      clr();
      run(32);
      chk("en17_hi_cnt", hi_cnt, 8);
      chk("en17_hi_mask", hi_mask, 32'h0000_00ff);
      duty_if.duty_valid = 1'b1;
      duty_if.duty_in = 5'd12;
      step(1);
      duty_if.duty_valid = 1'b0;
      chk("d12_same_ready", duty_if.duty_ready, 0);
      chk("d12_same_active", duty_active, 8);
      clr();
      run(31);
      chk("d12_old_hi", hi_cnt, 7);
      clr();
      step(1);
      chk("d12_next_active", duty_active, 12);
      chk("d12_next_ready", duty_if.duty_ready, 1);
      run(31);
      chk("d12_hi_cnt", hi_cnt, 12);
      chk("d12_hi_mask", hi_mask, 32'h0000_0fff);
      duty_if.duty_valid = 1'b1;
      duty_if.duty_in = 5'd5;
      step(1);
      duty_if.duty_valid = 1'b0;
      run(19);
      clr();
      step(27);
      run(2);
      step(3);
      chk("load_up_ps", ps_cnt, 0);
      chk("load_up_active", duty_active, 12);
      clr();
      step(4);
      chk("load_dn_ps", period_start, 1);
      chk("load_dn_active", duty_active, 5);
      chk("load_dn_pwm", pwm_out, 1);
      run(28);
      chk("load_hi_cnt", hi_cnt, 2);
      chk("load_hi_mask", hi_mask, 32'h0000_0018);
      step(1);
      duty_if.duty_valid = 1'b1;
      duty_if.duty_in = 5'd20;
      step(2);
      duty_if.duty_valid = 1'b0;
      run(30);
      step(1);
      chk("d20_active", duty_active, 20);
      step(2);
      chk("d20_pwm_c1", pwm_out, 1);
      enable = 1'b0;
      step(3);
      chk("dis_pwm", pwm_out, 0);
      enable = 1'b1;
      run(29);
      step(1);
      chk("reen_pwm", pwm_out, 1);
      step(2);
      #2 rst = 1'b0;
      #1;
      chk("arst_pwm", pwm_out, 0);
      chk("arst_active", duty_active, 0);
      chk("arst_ready", duty_if.duty_ready, 1);
      chk("arst_ps", period_start, 0);
      #2 rst = 1'b1;
      clr();
      repeat (3) step(count_in);
      run(10);
      chk("post_rst_ps", ps_cnt, 0);
      chk("post_rst_hi", hi_cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
